spi_ram_arbiter: RTL and testbench

- Shares one single-port synchronous RAM between two requesters:
  - the SPI slave's 10-bit command stream;
  - a local host port using a req/gnt handshake.
- Decodes SPI frames (write-address, write-data, read-address, read-data), keeps the SPI address registers, and arbitrates RAM cycles.
- Returns read data to the SPI slave's transmit side or to the host port.

---
 rtl/spi_ram_arbiter.sv | 170 +++++++++++++++++
 tb/tb_spi_ram_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_arbiter.sv
// Purpose: shares one single-port sync RAM between an SPI command stream and a host req/gnt port.
// Latency: winner picked in IDLE (N), RAM access N+1, read data valid N+3; SPI frame edge F -> earliest access F+2.
// Backpressure: host holds its request until host_gnt; SPI has no stall, a lost slot command sets sticky spi_ovf.
// Option: ARB_ROUND_ROBIN_EN selects round-robin tie-break; undefined gives fixed SPI priority.
module spi_ram_arbiter #(
   parameter int DATA_SIZE = 8,
   parameter int ADDR_SIZE = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DATA_SIZE+1:0]   spi_rx_data,
   input  logic                   spi_rx_valid,
   output logic [DATA_SIZE-1:0]   spi_tx_data,
   output logic                   spi_tx_valid,
   output logic                   spi_ovf,
   input  logic                   host_req,
   input  logic                   host_we,
   input  logic [ADDR_SIZE-1:0]   host_addr,
   input  logic [DATA_SIZE-1:0]   host_wdata,
   output logic                   host_gnt,
   output logic [DATA_SIZE-1:0]   host_rdata,
   output logic                   host_rvalid,
   output logic                   mem_en,
   output logic                   mem_we,
   output logic [ADDR_SIZE-1:0]   mem_addr,
   output logic [DATA_SIZE-1:0]   mem_wdata,
   input  logic [DATA_SIZE-1:0]   mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;

   state_t                 state;
   logic                   rx_vld_q;
   logic                   frame_edge;
   logic [1:0]             cmd;
   logic [DATA_SIZE-1:0]   payload;
   logic [ADDR_SIZE-1:0]   wr_addr;
   logic [ADDR_SIZE-1:0]   rd_addr;
   logic                   slot_vld;
   logic                   slot_we;
   logic [ADDR_SIZE-1:0]   slot_addr;
   logic [DATA_SIZE-1:0]   slot_wdata;
   logic                   cur_spi;
   logic                   cur_we;
   logic                   sel_spi;
   logic                   pending;
   logic                   slot_grant;
`ifdef ARB_ROUND_ROBIN_EN
   logic                   last_spi;
`endif

   // A frame is the first cycle spi_rx_valid is seen high; holding it high decodes nothing more.
   assign frame_edge = spi_rx_valid & ~rx_vld_q;
   assign cmd        = spi_rx_data[DATA_SIZE+1:DATA_SIZE];
   assign payload    = spi_rx_data[DATA_SIZE-1:0];
   assign pending    = slot_vld | host_req;
   assign slot_grant = (state == IDLE) & sel_spi;

   // Tie-break between a full SPI slot and a host request.
   always_comb begin
      sel_spi = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      sel_spi = slot_vld & (~host_req | ~last_spi);
`else
      sel_spi = slot_vld;
`endif
   end

   // SPI front end: frame decode, address registers, pending slot and overflow flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_vld_q   <= 1'b0;
         wr_addr    <= '0;
         rd_addr    <= '0;
         slot_vld   <= 1'b0;
         slot_we    <= 1'b0;
         slot_addr  <= '0;
         slot_wdata <= '0;
         spi_ovf    <= 1'b0;
      end else begin
         rx_vld_q <= spi_rx_valid;
         if (slot_grant)
            slot_vld <= 1'b0;
         if (frame_edge) begin
            case (cmd)
               2'b00: wr_addr <= payload[ADDR_SIZE-1:0];
               2'b10: rd_addr <= payload[ADDR_SIZE-1:0];
               default: begin
                  // A slot command that lands on a full, un-granted slot replaces it.
                  if (slot_vld && !slot_grant)
                     spi_ovf <= 1'b1;
                  slot_vld   <= 1'b1;
                  slot_we    <= ~cmd[1];
                  slot_addr  <= cmd[1] ? rd_addr : wr_addr;
                  slot_wdata <= payload;
               end
            endcase
         end
      end
   end

   // Arbitration FSM driving the RAM port and returning read data to its owner.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cur_spi      <= 1'b0;
         cur_we       <= 1'b0;
         mem_en       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         host_gnt     <= 1'b0;
         host_rdata   <= '0;
         host_rvalid  <= 1'b0;
         spi_tx_data  <= '0;
         spi_tx_valid <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_spi     <= 1'b0;
`endif
      end else begin
         host_rvalid <= 1'b0;
         case (state)
            IDLE: begin
               if (pending) begin
                  state   <= ACCESS;
                  mem_en  <= 1'b1;
                  cur_spi <= sel_spi;
`ifdef ARB_ROUND_ROBIN_EN
                  last_spi <= sel_spi;
`endif
                  if (sel_spi) begin
                     cur_we    <= slot_we;
                     mem_we    <= slot_we;
                     mem_addr  <= slot_addr;
                     mem_wdata <= slot_wdata;
                     host_gnt  <= 1'b0;
                  end else begin
                     cur_we    <= host_we;
                     mem_we    <= host_we;
                     mem_addr  <= host_addr;
                     mem_wdata <= host_wdata;
                     host_gnt  <= 1'b1;
                  end
               end
            end
            ACCESS: begin
               mem_en   <= 1'b0;
               mem_we   <= 1'b0;
               host_gnt <= 1'b0;
               state    <= cur_we ? IDLE : RDATA;
            end
            RDATA: begin
               if (cur_spi) begin
                  spi_tx_data  <= mem_rdata;
                  spi_tx_valid <= 1'b1;
               end else begin
                  host_rdata  <= mem_rdata;
                  host_rvalid <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // A new frame means the master has moved on; stale read data is withdrawn.
         if (frame_edge)
            spi_tx_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Purpose: directed checks of spi_ram_arbiter with a behavioural single-port RAM.
// Latency: expectations are cycle-exact relative to frame edges and host requests.
// Backpressure: host holds its request until grant; SPI frames are one-cycle valid pulses unless noted.
module tb_spi_ram_arbiter;

   logic       clk;
   logic       rst;
   logic [9:0] spi_rx_data;
   logic       spi_rx_valid;
   logic [7:0] spi_tx_data;
   logic       spi_tx_valid;
   logic       spi_ovf;
   logic       host_req;
   logic       host_we;
   logic [7:0] host_addr;
   logic [7:0] host_wdata;
   logic       host_gnt;
   logic [7:0] host_rdata;
   logic       host_rvalid;
   logic       mem_en;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;

   logic [7:0] ram [0:255];
   int vec = 0;
   int errs = 0;
   int en_cnt = 0;
   int rv_cnt = 0;
   int wr60_cnt = 0;

   spi_ram_arbiter #(.DATA_SIZE(8), .ADDR_SIZE(8)) dut (
      .clk(clk), .rst(rst),
      .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
      .spi_tx_data(spi_tx_data), .spi_tx_valid(spi_tx_valid), .spi_ovf(spi_ovf),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural synchronous RAM: read data appears the cycle after the enable.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata <= ram[mem_addr];
      end
   end

   // Event counters used for "exactly once" / "never" checks.
   always @(posedge clk) begin
      if (mem_en) en_cnt <= en_cnt + 1;
      if (host_rvalid) rv_cnt <= rv_cnt + 1;
      if (mem_en && mem_we && mem_addr == 8'h60) wr60_cnt <= wr60_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [9:0] f);
      spi_rx_data  = f;
      spi_rx_valid = 1'b1;
      tick();
      spi_rx_valid = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #1 rst = 1'b1;
      tick();
      tick();
      vec++; if ({mem_en, mem_we, host_gnt, host_rvalid, spi_tx_valid, spi_ovf} !== 6'b0) begin
         errs++; $display("FAIL reset_flags: got %b expected 000000", {mem_en, mem_we, host_gnt, host_rvalid, spi_tx_valid, spi_ovf}); end
      vec++; if ({mem_addr, mem_wdata} !== 16'h0) begin
         errs++; $display("FAIL reset_mem_bus: got %h expected 0000", {mem_addr, mem_wdata}); end
      vec++; if ({host_rdata, spi_tx_data} !== 16'h0) begin
         errs++; $display("FAIL reset_rdata: got %h expected 0000", {host_rdata, spi_tx_data}); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_spi_frames();
      send_frame(10'h005);
      send_frame(10'h1A5);
      vec++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 8'h05, 8'hA5}) begin
         errs++; $display("FAIL spi_write_access: got en=%b we=%b a=%h d=%h expected 1 1 05 a5", mem_en, mem_we, mem_addr, mem_wdata); end
      send_frame(10'h205);
      send_frame(10'h300);
      vec++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 8'h05}) begin
         errs++; $display("FAIL spi_read_access: got en=%b we=%b a=%h expected 1 0 05", mem_en, mem_we, mem_addr); end
      tick();
      vec++; if (spi_tx_valid !== 1'b0) begin
         errs++; $display("FAIL spi_tx_early: got %b expected 0", spi_tx_valid); end
      tick();
      vec++; if ({spi_tx_valid, spi_tx_data} !== {1'b1, 8'hA5}) begin
         errs++; $display("FAIL spi_tx_data: got v=%b d=%h expected 1 a5", spi_tx_valid, spi_tx_data); end
      tick();
      tick();
      vec++; if ({spi_tx_valid, spi_tx_data} !== {1'b1, 8'hA5}) begin
         errs++; $display("FAIL spi_tx_hold: got v=%b d=%h expected 1 a5", spi_tx_valid, spi_tx_data); end
      vec++; if (ram[5] !== 8'hA5) begin
         errs++; $display("FAIL ram5: got %h expected a5", ram[5]); end
      spi_rx_data  = 10'h000;
      spi_rx_valid = 1'b1;
      tick();
      vec++; if (spi_tx_valid !== 1'b0) begin
         errs++; $display("FAIL spi_tx_clear: got %b expected 0", spi_tx_valid); end
      spi_rx_valid = 1'b0;
      tick();
   endtask

   task automatic test_host();
      host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'h3C;
      tick();
      vec++; if ({host_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 8'h10, 8'h3C}) begin
         errs++; $display("FAIL host_wr_access: got g=%b en=%b we=%b a=%h d=%h expected 1 1 1 10 3c", host_gnt, mem_en, mem_we, mem_addr, mem_wdata); end
      host_req = 1'b0;
      tick();
      vec++; if (host_gnt !== 1'b0) begin
         errs++; $display("FAIL host_gnt_pulse: got %b expected 0", host_gnt); end
      host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
      tick();
      vec++; if ({host_gnt, mem_en, mem_we, mem_addr} !== {3'b110, 8'h10}) begin
         errs++; $display("FAIL host_rd_access: got g=%b en=%b we=%b a=%h expected 1 1 0 10", host_gnt, mem_en, mem_we, mem_addr); end
      host_req = 1'b0;
      tick();
      vec++; if (host_rvalid !== 1'b0) begin
         errs++; $display("FAIL host_rvalid_early: got %b expected 0", host_rvalid); end
      tick();
      vec++; if ({host_rvalid, host_rdata} !== {1'b1, 8'h3C}) begin
         errs++; $display("FAIL host_rdata: got v=%b d=%h expected 1 3c", host_rvalid, host_rdata); end
      tick();
      vec++; if (host_rvalid !== 1'b0) begin
         errs++; $display("FAIL host_rvalid_pulse: got %b expected 0", host_rvalid); end
   endtask

   task automatic test_arbitration();
      logic exp_gnt;
      send_frame(10'h030);
      host_we = 1'b1; host_addr = 8'h40; host_wdata = 8'h11;
      for (int i = 0; i < 4; i++) begin
         spi_rx_data  = {2'b01, 8'h70 + 8'(i)};
         spi_rx_valid = 1'b1;
         tick();
         spi_rx_valid = 1'b0;
         host_req     = 1'b1;
         tick();
`ifdef ARB_ROUND_ROBIN_EN
         exp_gnt = (i % 2 == 1);
`else
         exp_gnt = 1'b0;
`endif
         vec++; if ({mem_en, host_gnt} !== {1'b1, exp_gnt}) begin
            errs++; $display("FAIL tie_%0d: got en=%b gnt=%b expected 1 %b", i, mem_en, host_gnt, exp_gnt); end
      end
      host_req = 1'b0;
      spi_rx_valid = 1'b0;
      repeat (8) tick();
      do_reset();
   endtask

   task automatic test_held_valid();
      int e0;
      send_frame(10'h050);
      e0 = en_cnt;
      spi_rx_data  = 10'h199;
      spi_rx_valid = 1'b1;
      repeat (20) tick();
      spi_rx_valid = 1'b0;
      repeat (6) tick();
      vec++; if (en_cnt - e0 !== 1) begin
         errs++; $display("FAIL held_valid_count: got %0d accesses expected 1", en_cnt - e0); end
      vec++; if (ram[8'h50] !== 8'h99) begin
         errs++; $display("FAIL held_valid_ram: got %h expected 99", ram[8'h50]); end
   endtask

   task automatic test_ovf();
      int w0;
      vec++; if (spi_ovf !== 1'b0) begin
         errs++; $display("FAIL ovf_initial: got %b expected 0", spi_ovf); end
      send_frame(10'h060);
      w0 = wr60_cnt;
      host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
      spi_rx_data = 10'h1AA; spi_rx_valid = 1'b1;
      tick();
      vec++; if (host_gnt !== 1'b1) begin
         errs++; $display("FAIL ovf_host_gnt: got %b expected 1", host_gnt); end
      host_req = 1'b0; spi_rx_valid = 1'b0;
      tick();
      spi_rx_data = 10'h1BB; spi_rx_valid = 1'b1;
      tick();
      spi_rx_valid = 1'b0;
      vec++; if (spi_ovf !== 1'b1) begin
         errs++; $display("FAIL ovf_set: got %b expected 1", spi_ovf); end
      vec++; if ({host_rvalid, host_rdata} !== {1'b1, 8'h3C}) begin
         errs++; $display("FAIL ovf_host_rdata: got v=%b d=%h expected 1 3c", host_rvalid, host_rdata); end
      tick();
      vec++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 8'h60, 8'hBB}) begin
         errs++; $display("FAIL ovf_access: got en=%b we=%b a=%h d=%h expected 1 1 60 bb", mem_en, mem_we, mem_addr, mem_wdata); end
      repeat (6) tick();
      vec++; if (wr60_cnt - w0 !== 1 || ram[8'h60] !== 8'hBB) begin
         errs++; $display("FAIL ovf_single_write: got %0d writes ram=%h expected 1 bb", wr60_cnt - w0, ram[8'h60]); end
      vec++; if (spi_ovf !== 1'b1) begin
         errs++; $display("FAIL ovf_sticky: got %b expected 1", spi_ovf); end
   endtask

   task automatic test_reset_mid();
      int r0;
      host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
      tick();
      vec++; if (host_gnt !== 1'b1) begin
         errs++; $display("FAIL rstmid_gnt: got %b expected 1", host_gnt); end
      r0 = rv_cnt;
      rst = 1'b1;
      #1;
      vec++; if ({mem_en, mem_we, host_gnt, host_rvalid, spi_tx_valid, spi_ovf, mem_addr, host_rdata, spi_tx_data, mem_wdata} !== 38'h0) begin
         errs++; $display("FAIL rstmid_outputs: got en=%b we=%b g=%b rv=%b tv=%b ovf=%b expected all 0", mem_en, mem_we, host_gnt, host_rvalid, spi_tx_valid, spi_ovf); end
      host_req = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      repeat (5) tick();
      vec++; if (rv_cnt !== r0) begin
         errs++; $display("FAIL rstmid_no_rvalid: got %0d strobes expected 0", rv_cnt - r0); end
      host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
      tick();
      vec++; if ({host_gnt, mem_en} !== 2'b11) begin
         errs++; $display("FAIL rstmid_regnt: got g=%b en=%b expected 1 1", host_gnt, mem_en); end
      host_req = 1'b0;
      tick();
      tick();
      vec++; if ({host_rvalid, host_rdata} !== {1'b1, 8'h3C}) begin
         errs++; $display("FAIL rstmid_rdata: got v=%b d=%h expected 1 3c", host_rvalid, host_rdata); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 8'h00;
      mem_rdata    = 8'h00;
      spi_rx_data  = 10'h000;
      spi_rx_valid = 1'b0;
      host_req     = 1'b0;
      host_we      = 1'b0;
      host_addr    = 8'h00;
      host_wdata   = 8'h00;
      test_reset();
      test_spi_frames();
      test_host();
      test_arbitration();
      test_held_valid();
      test_ovf();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
